// File: rtl/mem_pkg.sv
// Shared types for the data-RAM requester: access sizes, FSM states and the RAM word width.
package mem_pkg;

  localparam int RAM_DW = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR0  = 3'd3,
    ST_WR1  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Natural alignment: the low address bits covered by the access size must be zero.
  function automatic logic is_aligned(input size_e size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0] == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      default: ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane helper: extracts and extends a load from a 32-bit word, and merges
// a byte/half store into a previously read word.
module lane_align
  import mem_pkg::*;
(
  input  logic [RAM_DW-1:0] i_word,
  input  size_e             i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_unsigned,
  input  logic [RAM_DW-1:0] i_wdata,
  output logic [63:0]       o_load,
  output logic [RAM_DW-1:0] o_merged
);

  logic [4:0]        w_bit_ofs;
  logic [RAM_DW-1:0] w_shifted;
  logic [RAM_DW-1:0] w_mask;
  logic [RAM_DW-1:0] w_data_sh;

  assign w_bit_ofs = {i_lane, 3'b000};
  assign w_shifted = i_word >> w_bit_ofs;
  assign w_data_sh = i_wdata << w_bit_ofs;

  always_comb begin
    o_load = '0;
    case (i_size)
      SZ_B: o_load = i_unsigned ? {56'd0, w_shifted[7:0]}
                                : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_load = i_unsigned ? {48'd0, w_shifted[15:0]}
                                : {{48{w_shifted[15]}}, w_shifted[15:0]};
      default: o_load = i_unsigned ? {32'd0, w_shifted}
                                   : {{32{w_shifted[31]}}, w_shifted};
    endcase
  end

  always_comb begin
    w_mask = '1;
    case (i_size)
      SZ_B:    w_mask = 32'h0000_00FF << w_bit_ofs;
      SZ_H:    w_mask = 32'h0000_FFFF << w_bit_ofs;
      default: w_mask = '1;
    endcase
  end

  assign o_merged = (i_word & ~w_mask) | (w_data_sh & w_mask);

endmodule

// File: rtl/ram_requester.sv
// Sequential master for a single-port 32-bit RAM: splits RV64 loads/stores into
// one or two word accesses, with read-modify-write for byte/half stores.
// Handshake: a request is taken on the rising edge where req_valid && req_ready;
// req_ready is high only in IDLE; resp_valid is a single-cycle pulse with no backpressure.
module ram_requester
  import mem_pkg::*;
#(
  parameter int N = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [N-1:0]      ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  input  logic [RAM_DW-1:0] ram_dout,
  output logic [2:0]        dbg_state
);

  localparam logic [N-1:0] ONE_W = 1;

  state_e            r_state;
  state_e            w_next;
  logic              r_we;
  size_e             r_size;
  logic              r_unsigned;
  logic [N-1:0]      r_widx;
  logic [1:0]        r_lane;
  logic [63:0]       r_wdata;
  logic [RAM_DW-1:0] r_lo;
  logic [63:0]       r_resp_rdata;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_aligned;
  size_e             w_req_size;
  logic [RAM_DW-1:0] w_align_word;
  logic [63:0]       w_load;
  logic [RAM_DW-1:0] w_merged;
  logic              w_enter_resp;
  logic [63:0]       w_resp_data;

  assign w_req_size = size_e'(req_size);
  assign w_accept   = req_valid && req_ready;
  assign w_aligned  = is_aligned(w_req_size, req_addr[2:0]);

  // RD0 feeds the live RAM word for loads; WR0 merges into the word captured in RD0.
  assign w_align_word = (r_state == ST_WR0) ? r_lo : ram_dout;

  lane_align u_lane_align (
    .i_word     (w_align_word),
    .i_size     (r_size),
    .i_lane     (r_lane),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata[31:0]),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_aligned)                                   w_next = ST_RESP;
          else if (req_we && (w_req_size == SZ_B || w_req_size == SZ_H)) w_next = ST_RD0;
          else if (req_we)                                  w_next = ST_WR0;
          else                                              w_next = ST_RD0;
        end
      end
      ST_RD0: begin
        if (r_we)                w_next = ST_WR0;
        else if (r_size == SZ_D) w_next = ST_RD1;
        else                     w_next = ST_RESP;
      end
      ST_RD1:  w_next = ST_RESP;
      ST_WR0:  w_next = (r_size == SZ_D) ? ST_WR1 : ST_RESP;
      ST_WR1:  w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

  always_comb begin
    w_resp_data = '0;
    case (r_state)
      ST_RD0:  w_resp_data = w_load;
      ST_RD1:  w_resp_data = {ram_dout, r_lo};
      default: w_resp_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_B;
      r_unsigned   <= 1'b0;
      r_widx       <= '0;
      r_lane       <= '0;
      r_wdata      <= '0;
      r_lo         <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= w_req_size;
        r_unsigned <= req_unsigned && (w_req_size != SZ_D);
        r_widx     <= req_addr[N+1:2];
        r_lane     <= req_addr[1:0];
        r_wdata    <= req_wdata;
      end
      if (r_state == ST_RD0) r_lo <= ram_dout;
      // Result registers only change on the way into RESP, so they hold between responses.
      if (w_enter_resp) begin
        r_resp_rdata <= w_resp_data;
        r_resp_err   <= (r_state == ST_IDLE);
      end
    end
  end

  // RAM drive is gated by rst_n so an asserted reset suppresses the write in flight.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (rst_n) begin
      case (r_state)
        ST_RD0: ram_addr = r_widx;
        ST_RD1: ram_addr = r_widx + ONE_W;
        ST_WR0: begin
          ram_we   = 1'b1;
          ram_addr = r_widx;
          ram_din  = (r_size == SZ_W || r_size == SZ_D) ? r_wdata[31:0] : w_merged;
        end
        ST_WR1: begin
          ram_we   = 1'b1;
          ram_addr = r_widx + ONE_W;
          ram_din  = r_wdata[63:32];
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = rst_n && (r_state == ST_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign dbg_state  = r_state;

endmodule

// File: doc/ram_requester.md
# ram_requester

Sequential master for the single-port 32-bit data RAM (synchronous write, combinational read, word-addressed, N address bits). Accepts byte/half/word/doubleword load and store requests from the RV64 core, using 64-bit byte addresses and 64-bit data. Splits each request into one or two 32-bit RAM word accesses and performs read-modify-write for sub-word stores. Returns one response per accepted request: load data, extended per RV64 rules, or a misalignment error.

## Interface
- N, 20, RAM word-address width; RAM data width is fixed at 32
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = double
- req_unsigned  in  1  zero-extend loads (LBU/LHU/LWU); ignored for double and for stores
- req_addr  in  64  byte address, little-endian
- req_wdata  in  64  store data, low-aligned (the byte to store is in [7:0])
- resp_valid  out  1  one-cycle pulse per accepted request; no backpressure
- resp_rdata  out  64  load result; 0 for stores and errors
- resp_err  out  1  misaligned access, valid with resp_valid
- ram_we  out  1  RAM write enable
- ram_addr  out  N  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, combinational from ram_addr

## Operation
- Word index: w = req_addr[N+1:2]. Address bits above N+1 are ignored. Byte lane: req_addr[1:0].
- Alignment:
  - half needs addr[0] = 0
  - word needs addr[1:0] = 0
  - double needs addr[2:0] = 0
  - A misaligned request goes straight to RESP with resp_err = 1. No RAM access and no write.
- An aligned double always has an even w, so w+1 never wraps modulo 2^N.
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
- Transitions out of IDLE on acceptance:
  - load B/H/W: IDLE → RD0 → RESP
  - load D: IDLE → RD0 → RD1 → RESP
  - store W: IDLE → WR0 → RESP
  - store D: IDLE → WR0 → WR1 → RESP
  - store B/H: IDLE → RD0 → WR0 → RESP
- Transitions out of RESP: always back to IDLE.
- Per-state RAM drive:
  - RD0: ram_addr = w; ram_dout is captured at the clock edge
  - RD1: ram_addr = w+1; ram_dout is captured as the upper word
  - WR0: ram_we = 1, ram_addr = w
    - store W/D: ram_din = wdata[31:0]
    - store B/H: ram_din = the captured word with the addressed byte or half replaced
  - WR1: ram_we = 1, ram_addr = w+1, ram_din = wdata[63:32]
  - In all other states: ram_we = 0, ram_addr = 0, ram_din = 0.
- Load result:
  - B/H/W: select the byte/half/word by lane, then sign-extend to 64 bits, or zero-extend if req_unsigned.
  - D: {upper word, lower word}.
- Request fields are latched on acceptance; req_* inputs are don't-care after that.

## Timing
- Acceptance in cycle 0; resp_valid asserts in:
  - cycle 1: error
  - cycle 2: load B/H/W, store W
  - cycle 3: load D, store D, store B/H
- req_ready is low from the cycle after acceptance through RESP, and returns high the cycle after RESP.
- Back-to-back throughput: one request per (latency + 1) cycles.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, ram_we 0, ram_addr 0, ram_din 0.
- Reset mid-operation aborts immediately and no response is issued.
  - A store D reset in WR1 leaves the low word written and the high word unchanged.
  - A store B/H reset in RD0 writes nothing.
- resp_rdata and resp_err hold their values after the RESP cycle until the next response.

## Structure
- Shared package mem_pkg holds:
  - the size_e enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - the state_e enum
  - the RAM data-width constant 32
- Sub-module lane_align (combinational) holds load byte-lane select and extension plus store merge. It is shared between the RD0 capture path and the WR0 data path.

## Test plan
- Store D 0x1122334455667788 to addr 0x4000, then load D from 0x4000:
  - RAM words 0x1000 = 0x55667788 and 0x1001 = 0x11223344
  - load returns the same 64-bit value at cycle 3 of the load
- Store B 0xAB to addr 0x4001 over word 0x55667788:
  - word becomes 0x5566AB88
  - ram_we is high only in WR0 (cycle 2)
  - resp_valid is high in cycle 3
- Load B from 0x4001 (word 0x5566AB88):
  - signed → 0xFFFFFFFFFFFFFFAB
  - unsigned → 0xAB
- Load W from 0x4004 with word 0x80000000:
  - signed → 0xFFFFFFFF80000000
  - unsigned → 0x0000000080000000
- Misaligned cases (store H at 0x4003, load D at 0x4004):
  - resp_err = 1 at cycle 1
  - ram_we never asserted; RAM contents unchanged
- rst_n low in WR1 of store D 0xAAAAAAAABBBBBBBB to addr 0x4008 (both words initially 0):
  - word 0x1002 = 0xBBBBBBBB, word 0x1003 = 0
  - no resp_valid
  - req_ready = 1 the cycle after reset is released
